// File: rtl/depacketizer_vc_if.sv
// depacketizer_vc_if: bundles the NoC-side flit port and the user-side
// packet port of the VC depacketizer.
//
// Handshakes:
//   flit side   : a flit moves when flit_in[FLIT_WIDTH-1] (its valid bit) and
//                 ready_out are both high at a clk edge.
//   packet side : a packet moves when valid_out and ready_in are both high at
//                 a clk edge; while valid_out is high and ready_in is low,
//                 data_out/dst_out/vc_out/nflits_out hold still.
// master is the depacketizer side, slave is the router/user side.
interface depacketizer_vc_if #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int FLIT_WIDTH       = 36,
  parameter int WIDTH_OUT        = 124
);
  logic [FLIT_WIDTH-1:0]       flit_in;
  logic                        ready_out;
  logic [WIDTH_OUT-1:0]        data_out;
  logic [ADDRESS_WIDTH-1:0]    dst_out;
  logic [VC_ADDRESS_WIDTH-1:0] vc_out;
  logic [2:0]                  nflits_out;
  logic                        valid_out;
  logic                        ready_in;
  logic                        error_out;

  modport master (
    input  flit_in, ready_in,
    output ready_out, data_out, dst_out, vc_out, nflits_out, valid_out, error_out
  );

  modport slave (
    output flit_in, ready_in,
    input  ready_out, data_out, dst_out, vc_out, nflits_out, valid_out, error_out
  );
endinterface

// File: rtl/depacketizer_vc.sv
// depacketizer_vc: reassembles head/body/tail flits from a NoC output port
// into one wide word presented with its destination and VC.
// Optional macro DEPACKETIZER_VC_CHECK_EN: when defined, body/tail flits
// whose vc field differs from the head's vc abort the packet with an error.
module depacketizer_vc #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int FLIT_WIDTH       = 36,
  parameter int MAX_FLITS        = 4,
  parameter int WIDTH_OUT        = 124
) (
  input  logic              clk,
  input  logic              rst,
  depacketizer_vc_if.master bus,
  output logic [1:0]        state_dbg_o
);

  // Payload bits per flit and data bits carried by the head flit.
  localparam int P = FLIT_WIDTH - 3 - VC_ADDRESS_WIDTH;
  localparam int H = P - ADDRESS_WIDTH;
  localparam logic [2:0] LAST_IDX = 3'(MAX_FLITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                      state_q;
  logic [2:0]                  count_q;
  logic [WIDTH_OUT-1:0]        data_q;
  logic [ADDRESS_WIDTH-1:0]    dst_q;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;
  logic [2:0]                  nflits_q;
  logic                        valid_q;
  logic                        error_q;

  // Flit field decode.
  logic                        f_valid;
  logic                        f_head;
  logic                        f_tail;
  logic [VC_ADDRESS_WIDTH-1:0] f_vc;
  logic [P-1:0]                f_payload;
  logic [WIDTH_OUT-1:0]        head_word;

  assign f_valid   = bus.flit_in[FLIT_WIDTH-1];
  assign f_head    = bus.flit_in[FLIT_WIDTH-2];
  assign f_tail    = bus.flit_in[FLIT_WIDTH-3];
  assign f_vc      = bus.flit_in[FLIT_WIDTH-4 -: VC_ADDRESS_WIDTH];
  assign f_payload = bus.flit_in[P-1:0];
  assign head_word = {{(WIDTH_OUT-H){1'b0}}, f_payload[H-1:0]};

  // Holding a packet blocks new flits unless the packet leaves this cycle,
  // which lets single-flit packets stream at one per cycle.
  logic ready;
  logic accept;
  logic capture;
  logic vc_bad;

  assign ready   = !rst && ((state_q != S_HOLD) || bus.ready_in);
  assign accept  = f_valid && ready;
  assign capture = accept && f_head;

`ifdef DEPACKETIZER_VC_CHECK_EN
  assign vc_bad = (f_vc != vc_q);
`else
  assign vc_bad = 1'b0;
`endif

  // Packet FSM: capture heads, fill body slots, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= 3'd0;
      data_q   <= '0;
      dst_q    <= '0;
      vc_q     <= '0;
      nflits_q <= 3'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (capture) begin
        // A head always starts a fresh packet; arriving mid-packet is an error.
        data_q <= head_word;
        dst_q  <= f_payload[P-1 -: ADDRESS_WIDTH];
        vc_q   <= f_vc;
        if (f_tail || (MAX_FLITS == 1)) begin
          state_q  <= S_HOLD;
          valid_q  <= 1'b1;
          nflits_q <= 3'd1;
          count_q  <= 3'd0;
          error_q  <= (state_q == S_COLLECT) || !f_tail;
        end else begin
          state_q <= S_COLLECT;
          valid_q <= 1'b0;
          count_q <= 3'd1;
          error_q <= (state_q == S_COLLECT);
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) error_q <= 1'b1;
          end
          S_COLLECT: begin
            if (accept) begin
              if (vc_bad) begin
                error_q <= 1'b1;
                state_q <= S_IDLE;
                count_q <= 3'd0;
              end else begin
                for (int k = 1; k < MAX_FLITS; k++) begin
                  if (count_q == 3'(k)) data_q[H+P*(k-1) +: P] <= f_payload;
                end
                if (f_tail || (count_q == LAST_IDX)) begin
                  // Slot table full without a tail is reported but still delivered.
                  state_q  <= S_HOLD;
                  valid_q  <= 1'b1;
                  nflits_q <= count_q + 3'd1;
                  count_q  <= 3'd0;
                  error_q  <= !f_tail;
                end else begin
                  count_q <= count_q + 3'd1;
                end
              end
            end
          end
          S_HOLD: begin
            if (bus.ready_in) begin
              valid_q <= 1'b0;
              state_q <= S_IDLE;
              if (accept) error_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ready_out  = ready;
  assign bus.data_out   = data_q;
  assign bus.dst_out    = dst_q;
  assign bus.vc_out     = vc_q;
  assign bus.nflits_out = nflits_q;
  assign bus.valid_out  = valid_q;
  assign bus.error_out  = error_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_depacketizer_vc.sv
// tb_depacketizer_vc: directed bench for depacketizer_vc with a packet-level
// reference model and literal spot checks.
// Honours DEPACKETIZER_VC_CHECK_EN to exercise the vc mismatch path.
module tb_depacketizer_vc;
  localparam int AW   = 4;
  localparam int VCW  = 1;
  localparam int FW   = 36;
  localparam int MAXF = 4;
  localparam int WO   = 124;
  localparam int P    = FW - 3 - VCW;
  localparam int H    = P - AW;
`ifdef DEPACKETIZER_VC_CHECK_EN
  localparam bit VC_CHK = 1'b1;
`else
  localparam bit VC_CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  depacketizer_vc_if #(.ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VCW),
                       .FLIT_WIDTH(FW), .WIDTH_OUT(WO)) bus ();
  logic [1:0] state_dbg;

  depacketizer_vc #(
    .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VCW), .FLIT_WIDTH(FW),
    .MAX_FLITS(MAXF), .WIDTH_OUT(WO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg_o(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packet-level view: a list of received payloads plus a pending output.
  bit            m_started = 1'b0;
  bit            m_pend    = 1'b0;
  bit            m_err     = 1'b0;
  bit            m_active  = 1'b0;
  logic [WO-1:0] m_data;
  logic [AW-1:0] m_dst;
  logic [VCW-1:0] m_vc;
  logic [2:0]    m_nfl;
  logic [H-1:0]  m_hdata;
  logic [AW-1:0] m_hdst;
  logic [VCW-1:0] m_hvc;
  logic [P-1:0]  exp_q[$];

  task automatic finish_pkt(bit tail_seen);
    m_pend   = 1'b1;
    m_active = 1'b0;
    m_dst    = m_hdst;
    m_vc     = m_hvc;
    m_nfl    = 3'(1 + exp_q.size());
    m_data   = WO'(m_hdata);
    foreach (exp_q[i]) m_data = m_data | (WO'(exp_q[i]) << (H + P*i));
    if (!tail_seen) m_err = 1'b1;
  endtask

  always @(posedge clk) begin
    logic [FW-1:0] f;
    bit rdy;
    f = bus.flit_in;
    m_started = 1'b1;
    if (rst) begin
      m_pend = 0; m_err = 0; m_active = 0;
      m_data = '0; m_dst = '0; m_vc = '0; m_nfl = '0;
      exp_q.delete();
    end else begin
      rdy   = !m_pend || bus.ready_in;
      m_err = 1'b0;
      if (m_pend && bus.ready_in) m_pend = 1'b0;
      if (f[FW-1] && rdy) begin
        if (f[FW-2]) begin
          if (m_active) m_err = 1'b1;
          m_active = 1'b1;
          m_hdata  = f[H-1:0];
          m_hdst   = f[P-1 -: AW];
          m_hvc    = f[FW-4 -: VCW];
          exp_q.delete();
          if (f[FW-3]) finish_pkt(1'b1);
        end else if (!m_active) begin
          m_err = 1'b1;
        end else if (VC_CHK && (f[FW-4 -: VCW] != m_hvc)) begin
          m_err    = 1'b1;
          m_active = 1'b0;
        end else begin
          exp_q.push_back(f[P-1:0]);
          if (f[FW-3]) finish_pkt(1'b1);
          else if (exp_q.size() + 1 == MAXF) finish_pkt(1'b0);
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_started) begin
      check("ready_out", 128'(bus.ready_out), 128'(!rst && (!m_pend || bus.ready_in)));
      check("valid_out", 128'(bus.valid_out), 128'(m_pend));
      check("error_out", 128'(bus.error_out), 128'(m_err));
      if (m_pend) begin
        check("data_out",   128'(bus.data_out),   128'(m_data));
        check("dst_out",    128'(bus.dst_out),    128'(m_dst));
        check("vc_out",     128'(bus.vc_out),     128'(m_vc));
        check("nflits_out", 128'(bus.nflits_out), 128'(m_nfl));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [FW-1:0] mk(bit h, bit t, logic [VCW-1:0] vc, logic [P-1:0] pl);
    return {1'b1, h, t, vc, pl};
  endfunction

  task automatic idle(int n);
    bus.flit_in = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a flit until it is accepted; returns 1 time unit after that edge.
  task automatic send(logic [FW-1:0] f);
    int t;
    bit acc;
    t   = 0;
    acc = 1'b0;
    bus.flit_in = f;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = bus.ready_out;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: flit %0h not accepted in 50 cycles", f);
    end
    bus.flit_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.flit_in  = '0;
    bus.ready_in = 1'b1;
    rst          = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_ready",  128'(bus.ready_out),  128'd0);
    check("rst_valid",  128'(bus.valid_out),  128'd0);
    check("rst_error",  128'(bus.error_out),  128'd0);
    check("rst_data",   128'(bus.data_out),   128'd0);
    check("rst_dst",    128'(bus.dst_out),    128'd0);
    check("rst_vc",     128'(bus.vc_out),     128'd0);
    check("rst_nflits", 128'(bus.nflits_out), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Single-flit packet.
    send(mk(1, 1, 1'b1, {4'h5, 28'h0ABCDEF}));
    check("t1_valid",  128'(bus.valid_out),  128'd1);
    check("t1_dst",    128'(bus.dst_out),    128'h5);
    check("t1_vc",     128'(bus.vc_out),     128'h1);
    check("t1_nflits", 128'(bus.nflits_out), 128'd1);
    check("t1_data",   128'(bus.data_out),   128'h0ABCDEF);
    idle(2);

    // Four-flit packet.
    send(mk(1, 0, 1'b0, {4'h3, 28'h1111111}));
    send(mk(0, 0, 1'b0, 32'hAAAA0001));
    send(mk(0, 0, 1'b0, 32'hAAAA0002));
    send(mk(0, 1, 1'b0, 32'hAAAA0003));
    check("t2_nflits", 128'(bus.nflits_out), 128'd4);
    check("t2_data",   128'(bus.data_out),   128'hAAAA0003_AAAA0002_AAAA0001_1111111);
    idle(2);

    // Backpressure: packet held for 5 cycles, next head waits.
    bus.ready_in = 1'b0;
    send(mk(1, 1, 1'b0, {4'h7, 28'h2222222}));
    bus.flit_in = mk(1, 1, 1'b1, {4'h9, 28'h3333333});
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("t3_ready_held", 128'(bus.ready_out), 128'd0);
    check("t3_valid_held", 128'(bus.valid_out), 128'd1);
    check("t3_dst_held",   128'(bus.dst_out),   128'h7);
    check("t3_data_held",  128'(bus.data_out),  128'h2222222);
    bus.ready_in = 1'b1;
    @(negedge clk);
    check("t3_ready_release", 128'(bus.ready_out), 128'd1);
    @(posedge clk);
    #1;
    bus.flit_in = '0;
    check("t3_next_valid", 128'(bus.valid_out), 128'd1);
    check("t3_next_dst",   128'(bus.dst_out),   128'h9);
    check("t3_next_data",  128'(bus.data_out),  128'h3333333);
    idle(2);

    // Body flit while idle.
    send(mk(0, 1, 1'b0, 32'hDEAD0000));
    check("t4_err",   128'(bus.error_out), 128'd1);
    check("t4_valid", 128'(bus.valid_out), 128'd0);
    idle(1);
    check("t4_err_drop", 128'(bus.error_out), 128'd0);
    idle(1);

    // Head mid-packet restarts capture.
    send(mk(1, 0, 1'b0, {4'h1, 28'h4444444}));
    send(mk(0, 0, 1'b0, 32'h55550001));
    send(mk(1, 0, 1'b0, {4'h2, 28'h6666666}));
    check("t5_err",   128'(bus.error_out), 128'd1);
    check("t5_valid", 128'(bus.valid_out), 128'd0);
    send(mk(0, 1, 1'b0, 32'h77770001));
    check("t5_err_after", 128'(bus.error_out),  128'd0);
    check("t5_nflits",    128'(bus.nflits_out), 128'd2);
    check("t5_dst",       128'(bus.dst_out),    128'h2);
    check("t5_data",      128'(bus.data_out),   128'h77770001_6666666);
    idle(2);

    // Overflow: four flits, no tail.
    send(mk(1, 0, 1'b0, {4'h4, 28'h0000001}));
    send(mk(0, 0, 1'b0, 32'h00000001));
    send(mk(0, 0, 1'b0, 32'h00000002));
    send(mk(0, 0, 1'b0, 32'h00000003));
    check("t6_err",    128'(bus.error_out),  128'd1);
    check("t6_valid",  128'(bus.valid_out),  128'd1);
    check("t6_nflits", 128'(bus.nflits_out), 128'd4);
    check("t6_data",   128'(bus.data_out),   128'h00000003_00000002_00000001_0000001);
    idle(2);

    // Reset mid-collect, then a fresh packet.
    send(mk(1, 0, 1'b0, {4'h6, 28'h8888888}));
    send(mk(0, 0, 1'b0, 32'h99990001));
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("t7_valid_rst", 128'(bus.valid_out), 128'd0);
    check("t7_err_rst",   128'(bus.error_out), 128'd0);
    send(mk(1, 1, 1'b0, {4'hA, 28'h0BEEF00}));
    check("t7_valid",  128'(bus.valid_out),  128'd1);
    check("t7_err",    128'(bus.error_out),  128'd0);
    check("t7_nflits", 128'(bus.nflits_out), 128'd1);
    check("t7_dst",    128'(bus.dst_out),    128'hA);
    check("t7_data",   128'(bus.data_out),   128'h0BEEF00);
    idle(2);

`ifdef DEPACKETIZER_VC_CHECK_EN
    // VC mismatch aborts the packet.
    send(mk(1, 0, 1'b1, {4'h3, 28'h1234567}));
    send(mk(0, 1, 1'b0, 32'hCAFE0001));
    check("t8_err",   128'(bus.error_out), 128'd1);
    check("t8_valid", 128'(bus.valid_out), 128'd0);
    idle(3);
    check("t8_valid_later", 128'(bus.valid_out), 128'd0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/depacketizer_vc.md
Name: depacketizer_vc

Overview:
- Sink-side counterpart of the VC packetizer. Sits between a NoC output (fabric) port and a user module.
- Accepts one flit per cycle from the router, validates the head/body/tail sequence and reassembles up to MAX_FLITS flits into one wide data word.
- Presents the word with its destination address and VC on a valid/ready interface.

Parameters:
- ADDRESS_WIDTH, 4, router address field width.
- VC_ADDRESS_WIDTH, 1, VC id field width.
- FLIT_WIDTH, 36, width of one flit on the NoC side.
- MAX_FLITS, 4, maximum flits per packet (1..4).
- WIDTH_OUT, 124, reassembled data width; must equal (FLIT_WIDTH-3-VC_ADDRESS_WIDTH-ADDRESS_WIDTH) + (MAX_FLITS-1)*(FLIT_WIDTH-3-VC_ADDRESS_WIDTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flit_in  in  FLIT_WIDTH  flit from router.
- ready_out  out  1  flit accept; a flit transfers when flit_in[FLIT_WIDTH-1] && ready_out.
- data_out  out  WIDTH_OUT  reassembled payload.
- dst_out  out  ADDRESS_WIDTH  address field of the head flit.
- vc_out  out  VC_ADDRESS_WIDTH  VC of the head flit.
- nflits_out  out  3  number of flits in the presented packet (1..MAX_FLITS).
- valid_out  out  1  packet valid.
- ready_in  in  1  downstream ready.
- error_out  out  1  one-cycle pulse on protocol error.

Behaviour:
- Flit layout, MSB first:
  - valid [F-1], head [F-2], tail [F-3].
  - vc [F-4 -: VC_ADDRESS_WIDTH].
  - payload below the vc field, P = F-3-VC_ADDRESS_WIDTH bits (32 at defaults).
  - Head flit: top ADDRESS_WIDTH payload bits are the destination; the remaining low H = P-ADDRESS_WIDTH bits (28) are data.
- Reassembly mapping:
  - data_out[H-1:0] = head data.
  - Body/tail flit k (k = 1..MAX_FLITS-1) goes to data_out[H+P*(k-1) +: P].
  - Slots not received read 0. All slots clear when a new head is accepted.
- FSM states: IDLE, COLLECT, HOLD.
  - IDLE: accepted head+tail flit -> capture, nflits=1, go HOLD. Accepted head without tail -> capture, count=1, go COLLECT. Accepted non-head flit -> drop, pulse error_out, stay IDLE.
  - COLLECT: accepted non-head flit -> store in slot count, count++. If tail -> go HOLD with nflits=count+1.
  - COLLECT, head flit received: abandon the partial packet, pulse error_out, restart capture with the new head (same transition rules as from IDLE).
  - COLLECT, overflow: the MAX_FLITS-th flit arrives without its tail bit -> store it, go HOLD, pulse error_out.
  - HOLD: valid_out=1; outputs stable until ready_in. On valid_out && ready_in -> IDLE, or directly capture a same-cycle head (see ready_out).
- ready_out = (state != HOLD) || ready_in. This is combinational and allows back-to-back single-flit packets at 1 packet/cycle.
- Latency: tail accepted in cycle N -> valid_out=1 in cycle N+1.
- Invalid flits (valid bit 0) are ignored in every state.
- Reset (rst=1 at clk edge):
  - State becomes IDLE; count, data_out, dst_out, vc_out, nflits_out all 0.
  - valid_out=0 and error_out=0.
  - ready_out=0 while rst is high.
  - A partially collected packet is discarded with no error pulse.

Optional Feature:
- DEPACKETIZER_VC_CHECK_EN.
- Defined: every body/tail flit's vc field must equal the captured head vc. On mismatch, pulse error_out, discard the partial packet, return to IDLE; the mismatching flit is dropped.
- Undefined: vc field of non-head flits is ignored; no mismatch error.

Test Plan:
- Single-flit packet, flit = valid|head|tail, vc=1, dst=4'h5, data=28'h0ABCDEF, ready_in=1 -> next cycle:
  - valid_out=1, dst_out=5, vc_out=1, nflits_out=1.
  - data_out[27:0]=0ABCDEF, upper bits 0.
- 4-flit packet: head (dst=3, data 28'h1111111), bodies 32'hAAAA0001 and 32'hAAAA0002, tail 32'hAAAA0003, ready_in=1 -> cycle after tail:
  - nflits_out=4.
  - data_out = {AAAA0003, AAAA0002, AAAA0001, 1111111}.
- Backpressure: ready_in=0 for 5 cycles after the first packet completes -> valid_out held with stable outputs, ready_out=0, next head not consumed. Raise ready_in -> next head accepted in that same cycle.
- Protocol errors:
  - Body flit while IDLE -> error_out pulses 1 cycle, no valid_out.
  - Head arriving mid-COLLECT -> error pulse, then the new 2-flit packet is delivered correctly.
- Overflow: 4 flits with no tail bit -> error_out pulse, valid_out=1 with nflits_out=4.
- Reset mid-COLLECT after 2 flits, then a fresh single-flit packet -> only the fresh packet is output, no error pulse. With DEPACKETIZER_VC_CHECK_EN: body flit vc=0 after head vc=1 -> error pulse, nothing delivered.
